// File: rtl/dm_access_scheduler_pkg.sv
// Shared data-memory request/response types and scheduler state encoding.
package dm_access_scheduler_pkg;

    typedef enum logic [1:0] {
        DM_WORD = 2'd0,
        DM_HALF = 2'd1,
        DM_BYTE = 2'd2
    } dm_size_t;

    typedef struct packed {
        logic [31:0] address;
        dm_size_t    size;
        logic        writeEnabled;
        logic [31:0] writeInput;
        logic        readSigned;
    } DM_in_t;

    typedef struct packed {
        logic [31:0] result;
    } DM_out_t;

    // Request driven on a memory port that must do nothing this cycle.
    localparam DM_in_t DM_IDLE = '{
        address:      32'd0,
        size:         DM_WORD,
        writeEnabled: 1'b0,
        writeInput:   32'd0,
        readSigned:   1'b0
    };

    typedef enum logic {
        SCHED_RUN    = 1'b0,
        SCHED_SPLIT2 = 1'b1
    } sched_state_t;

endpackage

// File: rtl/dm_access_scheduler_pair_hazard.sv
// Intra-pair read-after-write detector: an older store followed by a younger
// load to the same memory word inside one issued pair.
module dm_pair_hazard
    import dm_access_scheduler_pkg::*;
#(
    parameter int ADDR_HI = 12,
    parameter int ADDR_LO = 2
) (
    input  logic                       req_valid,
    input  logic                       req_first,
    input  logic                       use_a,
    input  logic                       use_b,
    input  logic [ADDR_HI-ADDR_LO:0]   word_a,
    input  logic [ADDR_HI-ADDR_LO:0]   word_b,
    input  logic                       we_a,
    input  logic                       we_b,
    output logic                       conflict,
    output logic                       older_is_a
);

    logic same_word;
    logic older_we;
    logic younger_we;

    // Pick older/younger by the order flag; only store-then-load on one word splits.
    always_comb begin
        older_is_a = !req_first;
        same_word  = (word_a == word_b);
        older_we   = req_first ? we_b : we_a;
        younger_we = req_first ? we_a : we_b;
        conflict   = req_valid && use_a && use_b && same_word && older_we && !younger_we;
    end

endmodule

// File: rtl/dm_access_scheduler.sv
// Schedules a MEM-stage instruction pair onto the dual-port data memory,
// splitting a same-word store->load pair across two cycles so the load sees
// the stored data.
//
// Handshake: upstream presents a pair with req_valid and must hold every req_*
// input stable until a clock edge at which req_ready is high; that edge
// consumes the pair. resp_valid marks the cycle whose resp_a/resp_b carry the
// pair's load results; there is no back-pressure on responses.
module dm_access_scheduler
    import dm_access_scheduler_pkg::*;
#(
    parameter int ADDR_HI = 12,
    parameter int ADDR_LO = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_first,
    input  logic             req_use_a,
    input  logic             req_use_b,
    input  DM_in_t           req_a,
    input  DM_in_t           req_b,
    output logic             req_ready,
    output DM_in_t           dm_inst_1,
    output DM_in_t           dm_inst_2,
    output logic             dm_first,
    input  DM_out_t          dm_out_1,
    input  DM_out_t          dm_out_2,
    output logic             resp_valid,
    output logic [31:0]      resp_a,
    output logic [31:0]      resp_b,
    output logic [CNT_W-1:0] split_count,
    output sched_state_t     dbg_state
);

    sched_state_t     state_q, state_d;
    logic [31:0]      hold_res_q, hold_res_d;
    logic [CNT_W-1:0] split_count_q, split_count_d;

    logic        conflict;
    logic        older_is_a;
    logic [31:0] res_a_live;
    logic [31:0] res_b_live;

    dm_pair_hazard #(
        .ADDR_HI (ADDR_HI),
        .ADDR_LO (ADDR_LO)
    ) u_hazard (
        .req_valid  (req_valid),
        .req_first  (req_first),
        .use_a      (req_use_a),
        .use_b      (req_use_b),
        .word_a     (req_a.address[ADDR_HI:ADDR_LO]),
        .word_b     (req_b.address[ADDR_HI:ADDR_LO]),
        .we_a       (req_a.writeEnabled),
        .we_b       (req_b.writeEnabled),
        .conflict   (conflict),
        .older_is_a (older_is_a)
    );

    // Unused slots and stores report zero; only loads return memory data.
    assign res_a_live = (req_use_a && !req_a.writeEnabled) ? dm_out_1.result : 32'd0;
    assign res_b_live = (req_use_b && !req_b.writeEnabled) ? dm_out_2.result : 32'd0;

    assign split_count = split_count_q;
    assign dbg_state   = state_q;

    // State, split-result capture and performance counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SCHED_RUN;
            hold_res_q    <= 32'd0;
            split_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_res_q    <= hold_res_d;
            split_count_q <= split_count_d;
        end
    end

    // Next state: a conflicting pair takes a second cycle for its younger slot.
    always_comb begin
        state_d       = state_q;
        hold_res_d    = hold_res_q;
        split_count_d = split_count_q;
        unique case (state_q)
            SCHED_RUN: begin
                if (req_valid && conflict) begin
                    state_d    = SCHED_SPLIT2;
                    hold_res_d = older_is_a ? res_a_live : res_b_live;
                    if (split_count_q != {CNT_W{1'b1}}) begin
                        split_count_d = split_count_q + CNT_W'(1);
                    end
                end
            end
            SCHED_SPLIT2: begin
                state_d = SCHED_RUN;
            end
            default: begin
                state_d = SCHED_RUN;
            end
        endcase
    end

    // Outputs: port steering, handshake and merged responses; all quiet in reset.
    always_comb begin
        dm_inst_1  = DM_IDLE;
        dm_inst_2  = DM_IDLE;
        dm_first   = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_a     = 32'd0;
        resp_b     = 32'd0;
        if (!reset) begin
            dm_first = req_first;
            unique case (state_q)
                SCHED_RUN: begin
                    req_ready = !(req_valid && conflict);
                    if (req_valid) begin
                        if (conflict) begin
                            if (older_is_a) dm_inst_1 = req_a;
                            else            dm_inst_2 = req_b;
                        end else begin
                            if (req_use_a) dm_inst_1 = req_a;
                            if (req_use_b) dm_inst_2 = req_b;
                            resp_valid = 1'b1;
                            resp_a     = res_a_live;
                            resp_b     = res_b_live;
                        end
                    end
                end
                SCHED_SPLIT2: begin
                    req_ready  = 1'b1;
                    resp_valid = 1'b1;
                    if (older_is_a) begin
                        if (req_use_b) dm_inst_2 = req_b;
                        resp_a = hold_res_q;
                        resp_b = res_b_live;
                    end else begin
                        if (req_use_a) dm_inst_1 = req_a;
                        resp_a = res_a_live;
                        resp_b = hold_res_q;
                    end
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dm_access_scheduler.md
Name: dm_access_scheduler

Overview:
- Sits between the superscalar MEM stage and the dual-slot data memory.
- Accepts one instruction pair per cycle (slot A, slot B, program-order flag) and forwards it to the memory ports.
- Detects an intra-pair read-after-write hazard (older store, younger load, same word) and splits the pair across two cycles. The memory's combinational read would otherwise return stale data.
- Merges split results, stalls upstream through req_ready, and keeps a saturating split counter.

Parameters:
- ADDR_HI, 12, MSB of the word-index field compared for conflicts.
- ADDR_LO, 2, LSB of the word-index field compared for conflicts.
- CNT_W, 16, width of the split_count performance counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  pair present from MEM stage
- req_first  in  1  0: slot A older; 1: slot B older
- req_use_a  in  1  slot A carries a memory op
- req_use_b  in  1  slot B carries a memory op
- req_a  in  DM_in_t  slot A request
- req_b  in  DM_in_t  slot B request
- req_ready  out  1  pair consumed at this clock edge
- dm_inst_1  out  DM_in_t  to memory port 1
- dm_inst_2  out  DM_in_t  to memory port 2
- dm_first  out  1  order flag to memory
- dm_out_1  in  DM_out_t  memory port 1 result
- dm_out_2  in  DM_out_t  memory port 2 result
- resp_valid  out  1  results valid this cycle
- resp_a  out  32  load result for slot A
- resp_b  out  32  load result for slot B
- split_count  out  CNT_W  number of split pairs, saturating

Behaviour:
- An unused or suppressed slot drives DM_IDLE: address 0, size DM_WORD, writeEnabled 0, writeInput 0, readSigned 0.
- Conflict: req_valid & use_a & use_b & req_a.address[ADDR_HI:ADDR_LO] == req_b.address[ADDR_HI:ADDR_LO] & older.writeEnabled & !younger.writeEnabled.
  - The older slot is chosen by req_first.
  - Older-load/younger-store pairs are not split.
  - Store/store pairs are not split; the memory's posedge-then-negedge write order already preserves program order.
- FSM states: RUN, SPLIT2.
- RUN, no conflict:
  - dm_inst_1 = use_a ? req_a : DM_IDLE; dm_inst_2 = use_b ? req_b : DM_IDLE; dm_first = req_first.
  - req_ready = 1; resp_valid = req_valid.
  - resp_a = dm_out_1.result; resp_b = dm_out_2.result. Zero latency, same cycle.
- RUN, conflict:
  - Drive only the older slot; the younger slot gets DM_IDLE. dm_first = req_first.
  - Capture the older slot's result into hold_res. req_ready = 0; resp_valid = 0.
  - Go to SPLIT2. split_count += 1, saturating at all-ones.
- SPLIT2:
  - Drive only the younger slot; the older slot gets DM_IDLE. dm_first = req_first.
  - req_ready = 1; resp_valid = 1.
  - Older slot's resp = hold_res; younger slot's resp = live dm_out result.
  - Go to RUN.
- Upstream holds req_* stable while req_ready = 0. Dropping req_valid in SPLIT2 is a protocol violation; the block still returns to RUN.
- req_valid = 0 in RUN: both ports DM_IDLE, resp_valid = 0, req_ready = 1.
- Responses for unused slots and for stores are 0.
- Reset, including mid-split:
  - State goes to RUN; hold_res = 0; split_count = 0.
  - While reset is high: req_ready = 0, resp_valid = 0, resp_a = resp_b = 0, both dm ports DM_IDLE, dm_first = 0.

Decomposition:
- Shared defs package:
  - DM_IDLE constant (DM_in_t) and the existing DM_in_t, DM_out_t, DM_WORD/HALF/BYTE.
  - New enum sched_state_t {SCHED_RUN, SCHED_SPLIT2}.
- One natural sub-module, dm_pair_hazard: combinational conflict detector. Outputs conflict plus older_is_a.
- FSM, capture register and counter stay in the top module.

Test Plan:
- Two independent loads: A lw 0x100, B lw 0x204, first=0, mem[0x100]=0x11, mem[0x204]=0x22. Required: resp_valid in the same cycle, resp_a=0x11, resp_b=0x22, req_ready=1, split_count=0.
- RAW split: A sw 0xDEADBEEF→0x40 (older, first=0), B lw 0x40. Required:
  - Cycle 1: ready=0, resp_valid=0, dm_inst_2 idle.
  - Cycle 2: ready=1, resp_b=0xDEADBEEF, resp_a=0.
  - split_count=1.
- Reversed order: same pair with first=1 (B older, load). Required: no split, resp_b equals the old mem value, mem[0x40]=0xDEADBEEF after the edge.
- Sub-word RAW: B sb 0xAB→0x43 older (first=1), A lbu 0x43, mem[0x40]=0. Required: split, resp_a=0x000000AB in cycle 2.
- Reset mid-split: assert reset in the cycle the FSM enters SPLIT2. Required: next cycle state=RUN, split_count=0, resp_valid=0; the pair is re-accepted after reset deasserts.
- Counter saturation: CNT_W=2, five consecutive conflicting pairs. Required: split_count reads 1, 2, 3, 3, 3.
